// File: rtl/seq_alu.sv
// Registered ALU with iterative unsigned multiply, divide and remainder.
// Latency: 1 edge for single-cycle ops and divide-by-zero, WIDTH+1 edges for MULU/DIVU/REMU.
// Backpressure: ready_o drops while an iterative op runs; valid_i is ignored until ready_o returns.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [SHW-1:0]   shamt_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             valid_o,
    output logic             divz_o
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_NAND  = 4'd2;
    localparam logic [3:0] OP_NOR   = 4'd3;
    localparam logic [3:0] OP_ADDU  = 4'd4;
    localparam logic [3:0] OP_SUBU  = 4'd5;
    localparam logic [3:0] OP_SLT   = 4'd6;
    localparam logic [3:0] OP_EQUAL = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_SRAV  = 4'd9;
    localparam logic [3:0] OP_LUI   = 4'd10;
    localparam logic [3:0] OP_SLTU  = 4'd11;
    localparam logic [3:0] OP_MULU  = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_REMU  = 4'd14;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] opc_q, opc_d;
    logic             busy_done;

    logic [3:0]       op_q;
    logic [WIDTH-1:0] s1_q, s2_q;
    logic [SHW-1:0]   sh_q;
    logic             pend_q;

    logic             accept;
    logic             is_multi;
    logic             divz_in;
    logic             pend_divz;
    logic [WIDTH-1:0] sc_res;
    logic [WIDTH-1:0] done_res;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    assign ready_o   = (state_q == IDLE);
    assign accept    = valid_i && ready_o;
    assign is_multi  = (ctrl_i == OP_MULU) || (ctrl_i == OP_DIVU) || (ctrl_i == OP_REMU);
    assign divz_in   = ((ctrl_i == OP_DIVU) || (ctrl_i == OP_REMU)) && (src2_i == '0);
    assign pend_divz = ((op_q == OP_DIVU) || (op_q == OP_REMU)) && (s2_q == '0);
    assign done_res  = (op_q == OP_DIVU) ? opc_q : acc_q;

    // Single-cycle results come from the operands captured at the accept edge.
    always_comb begin
        sc_res = '0;
        case (op_q)
            OP_AND:   sc_res = s1_q & s2_q;
            OP_OR:    sc_res = s1_q | s2_q;
            OP_NAND:  sc_res = ~(s1_q & s2_q);
            OP_NOR:   sc_res = ~(s1_q | s2_q);
            OP_ADDU:  sc_res = s1_q + s2_q;
            OP_SUBU:  sc_res = s1_q - s2_q;
            OP_SLT:   sc_res = {{(WIDTH-1){1'b0}}, ($signed(s1_q) < $signed(s2_q))};
            OP_EQUAL: sc_res = {{(WIDTH-1){1'b0}}, (s1_q == s2_q)};
            OP_SRA:   sc_res = $signed(s2_q) >>> sh_q;
            OP_SRAV:  sc_res = $signed(s2_q) >>> s1_q[SHW-1:0];
            OP_LUI:   sc_res = {s2_q[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SLTU:  sc_res = {{(WIDTH-1){1'b0}}, (s1_q < s2_q)};
            OP_DIVU:  sc_res = '1;
            OP_REMU:  sc_res = s1_q;
            default:  sc_res = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            opc_q   <= opc_d;
        end
    end

    // MULU: acc accumulates, opb is the shifting multiplicand, opc the multiplier.
    // DIVU/REMU: acc is the partial remainder, opb the divisor, opc shifts dividend into quotient.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        opc_d     = opc_q;
        busy_done = 1'b0;
        shifted   = {acc_q, opc_q[WIDTH-1]};
        diff      = shifted - {1'b0, opb_q};
        case (state_q)
            IDLE: begin
                if (valid_i && is_multi && !divz_in) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    acc_d   = '0;
                    opb_d   = (ctrl_i == OP_MULU) ? src1_i : src2_i;
                    opc_d   = (ctrl_i == OP_MULU) ? src2_i : src1_i;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(WIDTH)) begin
                    state_d   = IDLE;
                    busy_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (op_q == OP_MULU) begin
                        acc_d = opc_q[0] ? (acc_q + opb_q) : acc_q;
                        opb_d = opb_q << 1;
                        opc_d = opc_q >> 1;
                    end else if (!diff[WIDTH]) begin
                        acc_d = diff[WIDTH-1:0];
                        opc_d = {opc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = shifted[WIDTH-1:0];
                        opc_d = {opc_q[WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            sh_q   <= '0;
            pend_q <= 1'b0;
        end else begin
            pend_q <= 1'b0;
            if (accept) begin
                op_q   <= ctrl_i;
                s1_q   <= src1_i;
                s2_q   <= src2_i;
                sh_q   <= shamt_i;
                pend_q <= !is_multi || divz_in;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            result_o <= '0;
            zero_o   <= 1'b1;
            valid_o  <= 1'b0;
            divz_o   <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (pend_q) begin
                result_o <= sc_res;
                zero_o   <= (sc_res == '0);
                divz_o   <= pend_divz;
                valid_o  <= 1'b1;
            end else if (busy_done) begin
                result_o <= done_res;
                zero_o   <= (done_res == '0);
                divz_o   <= 1'b0;
                valid_o  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32: single-cycle stream, iterative ops, divide-by-zero, flush, reset.
module tb_seq_alu;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  ctrl_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic [4:0]  shamt_i;
    logic        flush_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic        valid_o;
    logic        divz_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [13];

    seq_alu #(.WIDTH(32)) dut (
        .clk_i    (clk_i),
        .rst_n    (rst_n),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .ctrl_i   (ctrl_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .shamt_i  (shamt_i),
        .flush_i  (flush_i),
        .result_o (result_o),
        .zero_o   (zero_o),
        .valid_o  (valid_o),
        .divz_o   (divz_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int low);
        valid_i = 1'b1;
        ctrl_i  = op;
        src1_i  = a;
        src2_i  = b;
        step();
        valid_i = 1'b0;
        lat = 0;
        low = 0;
        while (!valid_o && lat < 100) begin
            if (!ready_o) low++;
            step();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int low;
        int vcnt;

        vecs = '{
            '{4'd4,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0000},
            '{4'd6,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0001},
            '{4'd11, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0000},
            '{4'd8,  32'h0000_0000, 32'h8000_0000, 5'd4, 32'hF800_0000},
            '{4'd10, 32'h0000_0000, 32'h0000_1234, 5'd0, 32'h1234_0000},
            '{4'd5,  32'h0000_0000, 32'h0000_0001, 5'd0, 32'hFFFF_FFFF},
            '{4'd9,  32'h0000_0024, 32'h8000_0000, 5'd9, 32'hF800_0000},
            '{4'd7,  32'h0000_0005, 32'h0000_0005, 5'd0, 32'h0000_0001},
            '{4'd3,  32'h0000_0000, 32'h0000_0000, 5'd0, 32'hFFFF_FFFF},
            '{4'd2,  32'hFFFF_0000, 32'hFF00_FF00, 5'd0, 32'h00FF_FFFF},
            '{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h0000_0000},
            '{4'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000},
            '{4'd1,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hFFF0_FFF0}
        };

        rst_n   = 1'b0;
        valid_i = 1'b0;
        ctrl_i  = 4'd0;
        src1_i  = '0;
        src2_i  = '0;
        shamt_i = '0;
        flush_i = 1'b0;
        step();
        step();
        chk("rst_result", result_o, 32'h0);
        chk("rst_zero",   32'(zero_o),  32'h1);
        chk("rst_valid",  32'(valid_o), 32'h0);
        chk("rst_divz",   32'(divz_o),  32'h0);
        chk("rst_ready",  32'(ready_o), 32'h1);
        rst_n = 1'b1;
        step();

        // Back-to-back single-cycle ops with valid_i held high; result lags the accept by one edge.
        for (int i = 0; i <= 13; i++) begin
            if (i < 13) begin
                valid_i = 1'b1;
                ctrl_i  = vecs[i].op;
                src1_i  = vecs[i].a;
                src2_i  = vecs[i].b;
                shamt_i = vecs[i].sh;
            end else begin
                valid_i = 1'b0;
            end
            step();
            if (i > 0) begin
                chk($sformatf("stream%0d_result", i-1), result_o, vecs[i-1].exp);
                chk($sformatf("stream%0d_zero", i-1), 32'(zero_o), 32'(vecs[i-1].exp == 32'h0));
                chk($sformatf("stream%0d_valid", i-1), 32'(valid_o), 32'h1);
                chk($sformatf("stream%0d_ready", i-1), 32'(ready_o), 32'h1);
            end
        end
        shamt_i = '0;
        step();
        chk("stream_end_valid", 32'(valid_o), 32'h0);

        run_op(4'd12, 32'h0001_0003, 32'h0002_0005, lat, low);
        chk("mulu_result", result_o, 32'h000B_000F);
        chk("mulu_latency", 32'(lat), 32'd33);
        chk("mulu_ready_low", 32'(low), 32'd33);
        chk("mulu_ready_at_done", 32'(ready_o), 32'h1);
        chk("mulu_divz", 32'(divz_o), 32'h0);
        step();
        chk("mulu_valid_pulse", 32'(valid_o), 32'h0);

        run_op(4'd13, 32'd100, 32'd7, lat, low);
        chk("divu_result", result_o, 32'd14);
        chk("divu_latency", 32'(lat), 32'd33);
        run_op(4'd14, 32'd100, 32'd7, lat, low);
        chk("remu_result", result_o, 32'd2);
        chk("remu_latency", 32'(lat), 32'd33);

        run_op(4'd14, 32'd9, 32'd0, lat, low);
        chk("remu0_result", result_o, 32'd9);
        chk("remu0_divz", 32'(divz_o), 32'h1);
        chk("remu0_latency", 32'(lat), 32'd1);
        run_op(4'd13, 32'd5, 32'd0, lat, low);
        chk("divu0_result", result_o, 32'hFFFF_FFFF);
        chk("divu0_divz", 32'(divz_o), 32'h1);
        chk("divu0_latency", 32'(lat), 32'd1);
        chk("divu0_ready_low", 32'(low), 32'd0);

        // Flush an in-flight divide in its fifth busy cycle, then issue with flush still high.
        valid_i = 1'b1;
        ctrl_i  = 4'd13;
        src1_i  = 32'd1000;
        src2_i  = 32'd3;
        step();
        valid_i = 1'b0;
        repeat (4) step();
        chk("flush_busy_ready", 32'(ready_o), 32'h0);
        flush_i = 1'b1;
        step();
        chk("flush_valid", 32'(valid_o), 32'h0);
        chk("flush_ready", 32'(ready_o), 32'h1);
        chk("flush_result_kept", result_o, 32'hFFFF_FFFF);
        chk("flush_divz_kept", 32'(divz_o), 32'h1);
        valid_i = 1'b1;
        ctrl_i  = 4'd4;
        src1_i  = 32'd2;
        src2_i  = 32'd3;
        step();
        valid_i = 1'b0;
        flush_i = 1'b0;
        step();
        chk("post_flush_add", result_o, 32'd5);
        chk("post_flush_valid", 32'(valid_o), 32'h1);
        chk("post_flush_divz", 32'(divz_o), 32'h0);
        vcnt = 0;
        repeat (40) begin
            step();
            if (valid_o) vcnt++;
        end
        chk("flush_no_late_valid", 32'(vcnt), 32'd0);

        // Reset in the tenth busy cycle of a multiply.
        valid_i = 1'b1;
        ctrl_i  = 4'd12;
        src1_i  = 32'd7;
        src2_i  = 32'd6;
        step();
        valid_i = 1'b0;
        repeat (9) step();
        chk("midrst_busy_ready", 32'(ready_o), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("midrst_result", result_o, 32'h0);
        chk("midrst_zero", 32'(zero_o), 32'h1);
        chk("midrst_valid", 32'(valid_o), 32'h0);
        chk("midrst_ready", 32'(ready_o), 32'h1);
        #2;
        rst_n = 1'b1;
        vcnt = 0;
        repeat (40) begin
            step();
            if (valid_o) vcnt++;
        end
        chk("midrst_no_valid", 32'(vcnt), 32'd0);
        chk("midrst_ready_after", 32'(ready_o), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered ALU for the next CPU datapath revision.
- Keeps the full 4-bit control op set and adds iterative unsigned multiply, divide and remainder.
- Uses a valid/ready handshake and a registered result. Single-cycle ops sustain one op per cycle; MUL/DIV/REM stall the issuer via ready_o.
- Sits between the register-read stage and writeback; the EX stage stalls while ready_o is low.

Parameters:
- WIDTH, 32, operand/result width; even, at least 8.
- SHW, $clog2(WIDTH), shift-amount width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  operation request.
- ready_o  out  1  block can accept a request this cycle.
- ctrl_i  in  4  opcode.
- src1_i  in  WIDTH  operand 1.
- src2_i  in  WIDTH  operand 2.
- shamt_i  in  SHW  immediate shift amount (SRA only).
- flush_i  in  1  synchronous abort of an in-flight multi-cycle op.
- result_o  out  WIDTH  registered result.
- zero_o  out  1  registered; 1 iff result_o == 0.
- valid_o  out  1  one-cycle pulse: result_o/zero_o updated this cycle.
- divz_o  out  1  registered; 1 with valid_o when a DIVU/REMU had src2_i == 0.

Behaviour:
- Reset (async, rst_n=0): result_o=0, zero_o=1, valid_o=0, divz_o=0, ready_o=1, FSM=IDLE, counter=0, all iteration registers 0. Reset mid-operation discards the op; no valid_o follows.
- Accept: a request is taken on a rising edge where valid_i && ready_o. Operands and opcode are captured at that edge.
- Opcodes, single-cycle (result at edge after accept, latency 1):
  - 0 AND, 1 OR, 2 NAND, 3 NOR.
  - 4 ADDU, 5 SUBU: modulo 2^WIDTH; no overflow flag.
  - 6 SLT: signed src1<src2 -> {0..,1}.
  - 7 EQUAL: src1==src2 -> {0..,1}.
  - 8 SRA: src2 >>> shamt_i, arithmetic.
  - 9 SRAV: src2 >>> src1[SHW-1:0], arithmetic.
  - 10 LUI: {src2[WIDTH/2-1:0], WIDTH/2 zeros}.
  - 11 SLTU: unsigned src1<src2 -> {0..,1}.
  - 15: reserved; result 0, zero_o=1.
- Opcodes, multi-cycle:
  - 12 MULU: low WIDTH bits of unsigned product, shift-add.
  - 13 DIVU: unsigned quotient, restoring division.
  - 14 REMU: unsigned remainder, restoring division.
- FSM states: IDLE, BUSY.
  - IDLE: ready_o=1. Single-cycle op accepted -> result written next edge, valid_o=1, stays IDLE (back-to-back accepts allowed, throughput 1/cycle). Multi-cycle op accepted -> BUSY, counter=0.
  - BUSY: ready_o=0. One iteration per edge. After WIDTH iterations, the next edge writes result_o/zero_o and pulses valid_o, then -> IDLE. Latency is WIDTH+1 edges from the accept edge. ready_o returns to 1 in the valid_o cycle.
- Divide by zero (DIVU/REMU, src2==0): no iteration. Result at latency 1 with divz_o=1: DIVU -> all ones, REMU -> src1. The FSM never enters BUSY.
- flush_i:
  - In BUSY: next edge -> IDLE, no valid_o, result_o/zero_o keep their prior values.
  - In IDLE: no effect on the output registers; a request presented in the same cycle is still accepted.
- Outputs:
  - result_o, zero_o and divz_o hold their value between completions.
  - divz_o is cleared on every completion that is not a divide-by-zero.
  - valid_o is 0 except on the completion cycle.
- valid_i is ignored while ready_o=0. No queueing; the issuer must hold the request.

Test Plan:
- Reset mid-MULU: accept MULU 7*6, assert rst_n=0 at BUSY cycle 10 -> outputs return to reset values immediately; no valid_o after release; ready_o=1.
- Single-cycle stream, WIDTH=32, back-to-back with valid_i held high:
  - ADDU 0xFFFFFFFF+1 -> 0, zero_o=1.
  - SLT 0xFFFFFFFF,1 -> 1.
  - SLTU same operands -> 0.
  - SRA src2=0x80000000, shamt_i=4 -> 0xF8000000.
  - LUI src2=0x1234 -> 0x12340000.
  - Expect one valid_o per cycle.
- MULU 0x0001_0003*0x0002_0005: ready_o low 33 cycles, valid_o at edge 33 after accept, result 0x000B_000F.
- DIVU 100/7 -> 14, then REMU 100/7 -> 2, each latency 33; DIVU 5/0 -> 0xFFFFFFFF, divz_o=1, latency 1.
- Flush: DIVU 1000/3, flush_i at BUSY cycle 5 -> IDLE next edge, no valid_o, result_o keeps previous value; immediate ADDU 2+3 -> 5.
